// File: rtl/word_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : word_stack_pkg
//  Description : Shared opcode encodings for the stack calculator data stack.
//                Used by the instruction decoder (producer of op codes),
//                word_stack and its legality guard.
//  Revision    : 1.0  initial release
// ============================================================================
package word_stack_pkg;

  // Opcode field width
  localparam int STACK_OP_W = 4;

  // Opcodes 9..15 are reserved and always rejected
  typedef enum logic [STACK_OP_W-1:0] {
    STACK_OP_IDLE  = 4'd0,
    STACK_OP_PUSH  = 4'd1,
    STACK_OP_POP   = 4'd2,
    STACK_OP_SWAP  = 4'd3,
    STACK_OP_ROLL2 = 4'd4,
    STACK_OP_ROLL  = 4'd5,
    STACK_OP_CLEAR = 4'd6,
    STACK_OP_DUP   = 4'd7,
    STACK_OP_OVER  = 4'd8
  } stack_op_e;

endpackage : word_stack_pkg
`default_nettype wire

// File: rtl/word_stack_guard.sv
`default_nettype none
// ============================================================================
//  Module      : word_stack_guard
//  Description : Combinational legality check for a stack operation plus the
//                resulting occupancy. Illegal ops leave the count unchanged.
//  Ports       : op_i        - opcode
//                count_i     - current occupancy (0..DEPTH)
//                legal_o     - 1 when the op may be executed
//                count_nxt_o - occupancy after the op
//  Revision    : 1.0  initial release
// ============================================================================
module word_stack_guard
  import word_stack_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [STACK_OP_W-1:0]        op_i,
  input  logic [$clog2(DEPTH+1)-1:0]   count_i,
  output logic                         legal_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_nxt_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_MAX = CW'(DEPTH);

  logic has1;
  logic has2;
  logic not_full;

  assign has1     = (count_i != '0);
  assign has2     = (count_i >= CW'(2));
  assign not_full = (count_i != C_MAX);

  always_comb begin
    legal_o     = 1'b0;
    count_nxt_o = count_i;
    case (op_i)
      STACK_OP_IDLE: legal_o = 1'b1;
      STACK_OP_PUSH: begin
        legal_o = not_full;
        if (not_full) count_nxt_o = count_i + CW'(1);
      end
      STACK_OP_POP: begin
        legal_o = has1;
        if (has1) count_nxt_o = count_i - CW'(1);
      end
      STACK_OP_SWAP: legal_o = has2;
      STACK_OP_ROLL2: begin
        legal_o = has2;
        if (has2) count_nxt_o = count_i - CW'(1);
      end
      STACK_OP_ROLL: legal_o = has1;
      STACK_OP_CLEAR: begin
        legal_o     = 1'b1;
        count_nxt_o = '0;
      end
      STACK_OP_DUP: begin
        legal_o = has1 && not_full;
        if (has1 && not_full) count_nxt_o = count_i + CW'(1);
      end
      STACK_OP_OVER: begin
        legal_o = has2 && not_full;
        if (has2 && not_full) count_nxt_o = count_i + CW'(1);
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule : word_stack_guard
`default_nettype wire

// File: rtl/word_stack.sv
`default_nettype none
// ============================================================================
//  Module      : word_stack
//  Description : WIDTH x DEPTH data stack with occupancy tracking and guarded
//                operations (PUSH/POP/SWAP/ROLL2/ROLL/CLEAR/DUP/OVER).
//                Operations that would overflow/underflow are refused and
//                flagged by a one-cycle err pulse.
//  Ports       : clk, rst  - clock, asynchronous active-high reset
//                op_i      - opcode
//                d_i       - data for PUSH/ROLL/ROLL2
//                top_o     - entry 0 (0 when empty)
//                second_o  - entry 1 (0 when count<2)
//                count_o   - occupied entries
//                empty_o   - count==0
//                full_o    - count==DEPTH
//                err_o     - previous op was rejected
//  Revision    : 1.0  initial release
// ============================================================================
module word_stack
  import word_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STACK_OP_W-1:0]       op_i,
  input  logic [WIDTH-1:0]            d_i,
  output logic [WIDTH-1:0]            top_o,
  output logic [WIDTH-1:0]            second_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        err_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] e_q [DEPTH];
  logic [WIDTH-1:0] e_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             err_q;
  logic             legal;

  word_stack_guard #(
    .DEPTH (DEPTH)
  ) u_guard (
    .op_i        (op_i),
    .count_i     (count_q),
    .legal_o     (legal),
    .count_nxt_o (count_d)
  );

  // Entries at or above count are kept at zero: every downward shift only
  // happens when not full (so the discarded bottom entry is already zero) and
  // every upward shift fills the bottom with zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) e_d[i] = e_q[i];
    if (legal) begin
      case (op_i)
        STACK_OP_PUSH: begin
          for (int i = DEPTH-1; i > 0; i--) e_d[i] = e_q[i-1];
          e_d[0] = d_i;
        end
        STACK_OP_POP: begin
          for (int i = 0; i < DEPTH-1; i++) e_d[i] = e_q[i+1];
          e_d[DEPTH-1] = '0;
        end
        STACK_OP_SWAP: begin
          e_d[0] = e_q[1];
          e_d[1] = e_q[0];
        end
        STACK_OP_ROLL2: begin
          // Two operands consumed, one result written: net shift up by one
          e_d[0] = d_i;
          for (int i = 1; i < DEPTH-1; i++) e_d[i] = e_q[i+1];
          e_d[DEPTH-1] = '0;
        end
        STACK_OP_ROLL: e_d[0] = d_i;
        STACK_OP_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) e_d[i] = '0;
        end
        STACK_OP_DUP: begin
          for (int i = DEPTH-1; i > 0; i--) e_d[i] = e_q[i-1];
          e_d[0] = e_q[0];
        end
        STACK_OP_OVER: begin
          for (int i = DEPTH-1; i > 0; i--) e_d[i] = e_q[i-1];
          e_d[0] = e_q[1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= e_d[i];
      count_q <= count_d;
      err_q   <= ~legal;
    end
  end

  assign top_o    = e_q[0];
  assign second_o = e_q[1];
  assign count_o  = count_q;
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign err_o    = err_q;

endmodule : word_stack
`default_nettype wire

// File: tb/tb_word_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_stack
//  Description : Self-checking bench for word_stack. Two instances: the
//                default 8x8 stack driven with directed vectors, and a 16x4
//                stack driven with a pseudo-random op stream against a small
//                reference model. Expected results are queued by the drivers
//                and compared by independent monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_word_stack;
  import word_stack_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 8-bit x 8 instance ----------------
  logic [3:0] op8 = 4'd0;
  logic [7:0] d8  = 8'd0;
  logic [7:0] top8, sec8;
  logic [3:0] cnt8;
  logic       empty8, full8, err8;

  word_stack #(.WIDTH(8), .DEPTH(8)) u8 (
    .clk(clk), .rst(rst), .op_i(op8), .d_i(d8),
    .top_o(top8), .second_o(sec8), .count_o(cnt8),
    .empty_o(empty8), .full_o(full8), .err_o(err8)
  );

  // ---------------- 16-bit x 4 instance ----------------
  logic [3:0]  op4 = 4'd0;
  logic [15:0] d4  = 16'd0;
  logic [15:0] top4, sec4;
  logic [2:0]  cnt4;
  logic        empty4, full4, err4;

  word_stack #(.WIDTH(16), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .op_i(op4), .d_i(d4),
    .top_o(top4), .second_o(sec4), .count_o(cnt4),
    .empty_o(empty4), .full_o(full4), .err_o(err4)
  );

  typedef struct {
    logic [15:0] top;
    logic [15:0] sec;
    int          cnt;
    bit          err;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    #1;
    if (q8.size() != 0) begin
      e8 = q8.pop_front();
      check("u8.top",    32'(top8),   32'(e8.top[7:0]));
      check("u8.second", 32'(sec8),   32'(e8.sec[7:0]));
      check("u8.count",  32'(cnt8),   32'(e8.cnt));
      check("u8.err",    32'(err8),   32'(e8.err));
      check("u8.empty",  32'(empty8), 32'(e8.cnt == 0));
      check("u8.full",   32'(full8),  32'(e8.cnt == 8));
    end
  end

  always @(posedge clk) begin
    #1;
    if (q4.size() != 0) begin
      e4 = q4.pop_front();
      check("u4.top",    32'(top4),   32'(e4.top));
      check("u4.second", 32'(sec4),   32'(e4.sec));
      check("u4.count",  32'(cnt4),   32'(e4.cnt));
      check("u4.err",    32'(err4),   32'(e4.err));
      check("u4.empty",  32'(empty4), 32'(e4.cnt == 0));
      check("u4.full",   32'(full4),  32'(e4.cnt == 4));
      for (int i = 0; i < 4; i++)
        if (i >= e4.cnt) check("u4.zero_above_count", 32'(u4.e_q[i]), 32'd0);
    end
  end

  // ---------------- drivers ----------------
  task automatic drv8(input logic [3:0] o, input logic [7:0] dd,
                      input logic [7:0] et, input logic [7:0] es,
                      input int ec, input bit ee);
    exp_t x;
    @(negedge clk);
    op8 = o;
    d8  = dd;
    x.top = {8'd0, et};
    x.sec = {8'd0, es};
    x.cnt = ec;
    x.err = ee;
    q8.push_back(x);
  endtask

  // Reference model for the 4-deep instance
  logic [15:0] ms [4];
  int          mc = 0;

  task automatic drv4(input logic [3:0] o, input logic [15:0] dd);
    exp_t x;
    bit   ok;
    logic [15:0] t;
    @(negedge clk);
    op4 = o;
    d4  = dd;
    ok  = 1'b0;
    case (o)
      4'd0: ok = 1'b1;
      4'd1: if (mc < 4) begin
        ok = 1'b1;
        ms[3] = ms[2]; ms[2] = ms[1]; ms[1] = ms[0]; ms[0] = dd; mc++;
      end
      4'd2: if (mc >= 1) begin
        ok = 1'b1;
        ms[0] = ms[1]; ms[1] = ms[2]; ms[2] = ms[3]; ms[3] = 16'd0; mc--;
      end
      4'd3: if (mc >= 2) begin
        ok = 1'b1;
        t = ms[0]; ms[0] = ms[1]; ms[1] = t;
      end
      4'd4: if (mc >= 2) begin
        ok = 1'b1;
        ms[0] = dd; ms[1] = ms[2]; ms[2] = ms[3]; ms[3] = 16'd0; mc--;
      end
      4'd5: if (mc >= 1) begin
        ok = 1'b1;
        ms[0] = dd;
      end
      4'd6: begin
        ok = 1'b1;
        ms[0] = 16'd0; ms[1] = 16'd0; ms[2] = 16'd0; ms[3] = 16'd0; mc = 0;
      end
      4'd7: if (mc >= 1 && mc < 4) begin
        ok = 1'b1;
        ms[3] = ms[2]; ms[2] = ms[1]; ms[1] = ms[0]; mc++;
      end
      4'd8: if (mc >= 2 && mc < 4) begin
        ok = 1'b1;
        t = ms[1];
        ms[3] = ms[2]; ms[2] = ms[1]; ms[1] = ms[0]; ms[0] = t; mc++;
      end
      default: ok = 1'b0;
    endcase
    x.top = ms[0];
    x.sec = ms[1];
    x.cnt = mc;
    x.err = !ok;
    q4.push_back(x);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] lst [8];

  initial begin
    for (int i = 0; i < 4; i++) ms[i] = 16'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.top",    32'(top8),   32'd0);
    check("reset.second", 32'(sec8),   32'd0);
    check("reset.count",  32'(cnt8),   32'd0);
    check("reset.empty",  32'(empty8), 32'd1);
    check("reset.full",   32'(full8),  32'd0);
    check("reset.err",    32'(err8),   32'd0);
    rst = 1'b0;

    // Basic push / swap / roll2
    drv8(STACK_OP_PUSH,  8'h11, 8'h11, 8'h00, 1, 0);
    drv8(STACK_OP_PUSH,  8'h22, 8'h22, 8'h11, 2, 0);
    drv8(STACK_OP_PUSH,  8'h33, 8'h33, 8'h22, 3, 0);
    drv8(STACK_OP_SWAP,  8'h00, 8'h22, 8'h33, 3, 0);
    drv8(STACK_OP_ROLL2, 8'h55, 8'h55, 8'h11, 2, 0);
    drv8(STACK_OP_CLEAR, 8'h00, 8'h00, 8'h00, 0, 0);

    // Fill to DEPTH, overflow attempts, drain, underflow attempts
    for (int i = 1; i <= 8; i++)
      drv8(STACK_OP_PUSH, 8'(i), 8'(i), 8'(i-1), i, 0);
    drv8(STACK_OP_PUSH, 8'h09, 8'h08, 8'h07, 8, 1);
    drv8(STACK_OP_IDLE, 8'h00, 8'h08, 8'h07, 8, 0);
    drv8(STACK_OP_DUP,  8'h00, 8'h08, 8'h07, 8, 1);
    drv8(STACK_OP_OVER, 8'h00, 8'h08, 8'h07, 8, 1);
    for (int k = 1; k <= 8; k++)
      drv8(STACK_OP_POP, 8'h00, 8'(8-k), (k <= 6) ? 8'(7-k) : 8'h00, 8-k, 0);
    drv8(STACK_OP_POP,  8'h00, 8'h00, 8'h00, 0, 1);
    drv8(STACK_OP_SWAP, 8'h00, 8'h00, 8'h00, 0, 1);
    drv8(STACK_OP_ROLL, 8'h44, 8'h00, 8'h00, 0, 1);

    // ROLL2 on a full stack: bottom becomes 0, then verify by draining
    for (int i = 1; i <= 8; i++)
      drv8(STACK_OP_PUSH, 8'(i), 8'(i), 8'(i-1), i, 0);
    drv8(STACK_OP_ROLL2, 8'hAA, 8'hAA, 8'h06, 7, 0);
    drv8(STACK_OP_PUSH,  8'h77, 8'h77, 8'hAA, 8, 0);
    lst[0] = 8'h77; lst[1] = 8'hAA; lst[2] = 8'h06; lst[3] = 8'h05;
    lst[4] = 8'h04; lst[5] = 8'h03; lst[6] = 8'h02; lst[7] = 8'h01;
    for (int j = 1; j <= 7; j++)
      drv8(STACK_OP_POP, 8'h00, lst[j], (j < 7) ? lst[j+1] : 8'h00, 8-j, 0);
    drv8(STACK_OP_CLEAR, 8'h00, 8'h00, 8'h00, 0, 0);

    // OVER / DUP / reserved op / ROLL
    drv8(STACK_OP_PUSH, 8'hB0, 8'hB0, 8'h00, 1, 0);
    drv8(STACK_OP_PUSH, 8'hA0, 8'hA0, 8'hB0, 2, 0);
    drv8(STACK_OP_OVER, 8'h00, 8'hB0, 8'hA0, 3, 0);
    drv8(STACK_OP_DUP,  8'h00, 8'hB0, 8'hB0, 4, 0);
    drv8(4'd12,         8'h5A, 8'hB0, 8'hB0, 4, 1);
    drv8(STACK_OP_ROLL, 8'hC3, 8'hC3, 8'hB0, 4, 0);

    // CLEAR on a full stack
    for (int i = 1; i <= 4; i++)
      drv8(STACK_OP_PUSH, 8'(i), 8'(i), (i == 1) ? 8'hC3 : 8'(i-1), 4+i, 0);
    drv8(STACK_OP_CLEAR, 8'h00, 8'h00, 8'h00, 0, 0);
    drv8(STACK_OP_IDLE,  8'h00, 8'h00, 8'h00, 0, 0);

    // Asynchronous reset between clock edges
    for (int i = 1; i <= 5; i++)
      drv8(STACK_OP_PUSH, 8'(i), 8'(i), 8'(i-1), i, 0);
    drv8(STACK_OP_IDLE, 8'h00, 8'h05, 8'h04, 5, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst.count",  32'(cnt8),   32'd0);
    check("async_rst.top",    32'(top8),   32'd0);
    check("async_rst.second", 32'(sec8),   32'd0);
    check("async_rst.empty",  32'(empty8), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Pseudo-random stream on the 16x4 instance
    for (int n = 0; n < 300; n++) begin
      logic [3:0] o;
      if ($urandom_range(0, 9) < 3) o = STACK_OP_PUSH;
      else if ($urandom_range(0, 19) == 0) o = STACK_OP_CLEAR;
      else o = 4'($urandom_range(0, 15));
      if (o == STACK_OP_CLEAR && $urandom_range(0, 3) != 0) o = STACK_OP_DUP;
      drv4(o, 16'($urandom));
    end
    drv4(STACK_OP_IDLE, 16'h0000);

    repeat (3) @(posedge clk);
    #2;
    check("drain.q8", 32'(q8.size()), 32'd0);
    check("drain.q4", 32'(q4.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule : tb_word_stack
`default_nettype wire
